// File: rtl/ptp_ts_loopback_latency.sv
// ptp_ts_loopback_latency
// Pairs egress PTP timestamps with the ingress timestamps of the same frames
// coming back on a loopback path, in FIFO order. Each pair produces one
// latency result in 2^-16 ns units, and running min/max/count statistics are
// kept for the results.
// Data path: egress FIFO -> stage 1 (second/ns/fns differences) ->
// stage 2 (combine, clamp, output register).
module ptp_ts_loopback_latency #(
  parameter int PTP_TS_WIDTH = 96,
  parameter int FIFO_DEPTH   = 16,
  parameter int LAT_WIDTH    = 32,
  parameter int TIMEOUT      = 65535,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PTP_TS_WIDTH-1:0]       s_axis_tx_ts,
  input  logic                          s_axis_tx_ts_valid,
  output logic                          s_axis_tx_ts_ready,
  input  logic [PTP_TS_WIDTH-1:0]       s_axis_rx_ts,
  input  logic                          s_axis_rx_ts_valid,
  output logic                          s_axis_rx_ts_ready,
  output logic [LAT_WIDTH-1:0]          m_axis_lat,
  output logic                          m_axis_lat_sat,
  output logic                          m_axis_lat_valid,
  input  logic                          m_axis_lat_ready,
  input  logic                          stat_clear,
  output logic [CNT_WIDTH-1:0]          stat_count,
  output logic [CNT_WIDTH-1:0]          stat_lost,
  output logic [CNT_WIDTH-1:0]          stat_orphan,
  output logic [LAT_WIDTH-1:0]          stat_min,
  output logic [LAT_WIDTH-1:0]          stat_max,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  // ns difference width: covers 48-bit ns (64-bit format) plus sign and the
  // one-second carry of the 96-bit format.
  localparam int DW = 50;
  localparam int XW = DW + 16;
  localparam logic [LW-1:0] DEPTH_L = FIFO_DEPTH[LW-1:0];
  localparam logic [31:0]   TMO     = TIMEOUT[31:0];

  logic [PTP_TS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [PTP_TS_WIDTH-1:0] head;
  logic [31:0]             tmo_cnt;

  logic fifo_empty, push, pop, rx_acc, match, orphan, tmo_hit;
  logic s1_ready, s2_ready, s2_load;

  logic [DW-1:0] dns_c;
  logic [16:0]   dfns_c;
  logic          sat_hi_c, sat_lo_c;

  logic          s1_valid;
  logic [DW-1:0] s1_dns;
  logic [16:0]   s1_dfns;
  logic          s1_sat_hi, s1_sat_lo;

  logic [XW-1:0]        lat_x;
  logic                 lat_neg, lat_big;
  logic [LAT_WIDTH-1:0] res_lat;
  logic                 res_sat;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign head       = mem[rd_ptr];
  assign fifo_empty = (fifo_level == '0);

  assign s_axis_tx_ts_ready = (fifo_level < DEPTH_L);
  assign push = s_axis_tx_ts_valid & s_axis_tx_ts_ready;

  assign s2_ready = !m_axis_lat_valid || m_axis_lat_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign s2_load  = s1_valid && s2_ready;

  assign s_axis_rx_ts_ready = s1_ready;
  assign rx_acc = s_axis_rx_ts_valid && s1_ready;
  assign match  = rx_acc && !fifo_empty;
  assign orphan = rx_acc && fifo_empty;

  // A match in the timeout cycle consumes the head, so the loss never fires.
  assign tmo_hit = (TIMEOUT != 0) && !fifo_empty && (tmo_cnt == TMO) && !match;
  assign pop     = match || tmo_hit;

  // Egress timestamp storage; contents need no reset, pointers guard validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_axis_tx_ts;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Head-of-FIFO age counter for loss detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (pop || fifo_empty || (TIMEOUT == 0)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign dfns_c = {1'b0, s_axis_rx_ts[15:0]} - {1'b0, head[15:0]};

  generate
    if (PTP_TS_WIDTH == 96) begin : g_ts96
      logic [47:0] rx_sec, tx_sec, d_sec;
      logic [31:0] rx_ns, tx_ns;
      assign rx_sec = s_axis_rx_ts[95:48];
      assign tx_sec = head[95:48];
      assign rx_ns  = s_axis_rx_ts[47:16];
      assign tx_ns  = head[47:16];
      assign d_sec  = rx_sec - tx_sec;

      // Nanosecond difference with one second of carry; wider gaps saturate.
      always_comb begin
        dns_c    = '0;
        sat_hi_c = 1'b0;
        sat_lo_c = 1'b0;
        if (rx_sec < tx_sec) begin
          sat_lo_c = 1'b1;
        end else if (d_sec == 48'd0) begin
          dns_c = {18'd0, rx_ns} - {18'd0, tx_ns};
        end else if (d_sec == 48'd1) begin
          dns_c = {18'd0, rx_ns} + 50'd1000000000 - {18'd0, tx_ns};
        end else begin
          sat_hi_c = 1'b1;
        end
      end
    end else begin : g_ts64
      assign dns_c    = {2'b00, s_axis_rx_ts[63:16]} - {2'b00, head[63:16]};
      assign sat_hi_c = 1'b0;
      assign sat_lo_c = 1'b0;
    end
  endgenerate

  // Stage 1: capture differences of the matched pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_dns    <= '0;
      s1_dfns   <= '0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
    end else if (match) begin
      s1_valid  <= 1'b1;
      s1_dns    <= dns_c;
      s1_dfns   <= dfns_c;
      s1_sat_hi <= sat_hi_c;
      s1_sat_lo <= sat_lo_c;
    end else if (s2_load) begin
      s1_valid  <= 1'b0;
    end
  end

  // Two's complement (dns << 16) + sign-extended dfns.
  assign lat_x   = {s1_dns, 16'd0} + {{(XW-17){s1_dfns[16]}}, s1_dfns};
  assign lat_neg = lat_x[XW-1];
  assign lat_big = |lat_x[XW-2:LAT_WIDTH];

  // Clamp the combined latency into the output range.
  always_comb begin
    res_lat = lat_x[LAT_WIDTH-1:0];
    res_sat = 1'b0;
    if (s1_sat_lo || lat_neg) begin
      res_lat = '0;
      res_sat = 1'b1;
    end else if (s1_sat_hi || lat_big) begin
      res_lat = '1;
      res_sat = 1'b1;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_lat_valid <= 1'b0;
      m_axis_lat       <= '0;
      m_axis_lat_sat   <= 1'b0;
    end else if (s2_load) begin
      m_axis_lat_valid <= 1'b1;
      m_axis_lat       <= res_lat;
      m_axis_lat_sat   <= res_sat;
    end else if (m_axis_lat_ready) begin
      m_axis_lat_valid <= 1'b0;
    end
  end

  // Saturating statistics; a clear discards same-cycle events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count  <= '0;
      stat_lost   <= '0;
      stat_orphan <= '0;
      stat_min    <= '1;
      stat_max    <= '0;
    end else if (stat_clear) begin
      stat_count  <= '0;
      stat_lost   <= '0;
      stat_orphan <= '0;
      stat_min    <= '1;
      stat_max    <= '0;
    end else begin
      if (s2_load) begin
        stat_count <= sat_inc(stat_count);
        if (!res_sat) begin
          if (res_lat < stat_min) stat_min <= res_lat;
          if (res_lat > stat_max) stat_max <= res_lat;
        end
      end
      if (tmo_hit) stat_lost   <= sat_inc(stat_lost);
      if (orphan)  stat_orphan <= sat_inc(stat_orphan);
    end
  end

endmodule

// File: tb/tb_ptp_ts_loopback_latency.sv
// Bench for ptp_ts_loopback_latency: 96-bit timestamps, 4-entry FIFO,
// 100-cycle timeout. Expected results go into a queue when the ingress
// timestamp is driven and are popped when the DUT hands a result over.
module tb_ptp_ts_loopback_latency;

  localparam int TSW = 96, DEPTH = 4, LATW = 32, TMO = 100, CW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [TSW-1:0]  tx_ts, rx_ts;
  logic            tx_valid, tx_ready, rx_valid, rx_ready;
  logic [LATW-1:0] m_lat;
  logic            m_sat, m_valid, m_ready;
  logic            stat_clear;
  logic [CW-1:0]   stat_count, stat_lost, stat_orphan;
  logic [LATW-1:0] stat_min, stat_max;
  logic [2:0]      fifo_level;

  always #5 clk = ~clk;

  ptp_ts_loopback_latency #(
    .PTP_TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH), .LAT_WIDTH(LATW),
    .TIMEOUT(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tx_ts(tx_ts), .s_axis_tx_ts_valid(tx_valid), .s_axis_tx_ts_ready(tx_ready),
    .s_axis_rx_ts(rx_ts), .s_axis_rx_ts_valid(rx_valid), .s_axis_rx_ts_ready(rx_ready),
    .m_axis_lat(m_lat), .m_axis_lat_sat(m_sat), .m_axis_lat_valid(m_valid),
    .m_axis_lat_ready(m_ready), .stat_clear(stat_clear),
    .stat_count(stat_count), .stat_lost(stat_lost), .stat_orphan(stat_orphan),
    .stat_min(stat_min), .stat_max(stat_max), .fifo_level(fifo_level)
  );

  typedef struct { logic [31:0] lat; logic sat; } exp_t;
  typedef struct { logic [95:0] tx; logic [95:0] rx; logic [31:0] lat; logic sat; } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] held;

  function automatic logic [95:0] mk(input longint sec, input longint ns, input int fns);
    return {sec[47:0], ns[31:0], fns[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [95:0] ts);
    int n = 0;
    while (!tx_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL tx_ready_wait: got no ready in %0d cycles expected ready", n);
    end
    tx_valid = 1'b1;
    tx_ts    = ts;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [95:0] ts, input logic has_exp,
                         input logic [31:0] lat, input logic sat);
    int n = 0;
    while (!rx_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL rx_ready_wait: got no ready in %0d cycles expected ready", n);
    end
    if (has_exp) sbq.push_back('{lat: lat, sat: sat});
    rx_valid = 1'b1;
    rx_ts    = ts;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || m_valid) && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
    end
  endtask

  task automatic clear_stats();
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
  endtask

  // Scoreboard: the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sbq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: got lat 0x%0h expected no output", m_lat);
      end else begin
        mon_e = sbq.pop_front();
        check("out_lat", {32'd0, m_lat}, {32'd0, mon_e.lat});
        check("out_sat", {63'd0, m_sat}, {63'd0, mon_e.sat});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mk(7, 999999900, 0),   mk(8, 100, 0),          32'h00C80000, 1'b0};
    vecs[1] = '{mk(10, 0, 0),          mk(12, 0, 0),           32'hFFFFFFFF, 1'b1};
    vecs[2] = '{mk(20, 500, 0),        mk(19, 900, 0),         32'h00000000, 1'b1};
    vecs[3] = '{mk(3, 100, 0),         mk(3, 50, 0),           32'h00000000, 1'b1};
    vecs[4] = '{mk(1, 0, 'h8000),      mk(1, 1, 0),            32'h00008000, 1'b0};
    vecs[5] = '{mk(2, 0, 0),           mk(2, 65535, 'hFFFF),   32'hFFFFFFFF, 1'b0};
    vecs[6] = '{mk(2, 0, 0),           mk(2, 65536, 0),        32'hFFFFFFFF, 1'b1};
    vecs[7] = '{mk(4, 999999999, 'hFFFF), mk(5, 0, 0),         32'h00000001, 1'b0};

    rst_n = 1'b0; tx_ts = '0; rx_ts = '0; tx_valid = 1'b0; rx_valid = 1'b0;
    m_ready = 1'b1; stat_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  {63'd0, m_valid}, 64'd0);
    check("rst_lat",    {32'd0, m_lat}, 64'd0);
    check("rst_count",  {32'd0, stat_count}, 64'd0);
    check("rst_lost",   {32'd0, stat_lost}, 64'd0);
    check("rst_orphan", {32'd0, stat_orphan}, 64'd0);
    check("rst_min",    {32'd0, stat_min}, 64'hFFFFFFFF);
    check("rst_max",    {32'd0, stat_max}, 64'd0);
    check("rst_level",  {61'd0, fifo_level}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Ingress timestamp with nothing pending.
    send_rx(mk(1, 0, 0), 1'b0, 32'd0, 1'b0);
    repeat (3) tick();
    check("orphan_cnt",   {32'd0, stat_orphan}, 64'd1);
    check("orphan_count", {32'd0, stat_count}, 64'd0);

    // First pair with exact output timing.
    push_tx(mk(5, 1000, 0));
    sbq.push_back('{lat: 32'h028A8000, sat: 1'b0});
    rx_valid = 1'b1; rx_ts = mk(5, 1650, 'h8000);
    tick();
    rx_valid = 1'b0;
    check("valid_cycle1", {63'd0, m_valid}, 64'd0);
    tick();
    check("valid_cycle2", {63'd0, m_valid}, 64'd1);
    check("first_lat",    {32'd0, m_lat}, 64'h028A8000);
    tick();
    check("first_count", {32'd0, stat_count}, 64'd1);
    check("first_min",   {32'd0, stat_min}, 64'h028A8000);
    check("first_max",   {32'd0, stat_max}, 64'h028A8000);

    clear_stats();
    check("clr_count",  {32'd0, stat_count}, 64'd0);
    check("clr_orphan", {32'd0, stat_orphan}, 64'd0);
    check("clr_min",    {32'd0, stat_min}, 64'hFFFFFFFF);
    check("clr_max",    {32'd0, stat_max}, 64'd0);

    // Table: rollover, saturation and range-edge pairs.
    for (int i = 0; i < 8; i++) begin
      push_tx(vecs[i].tx);
      send_rx(vecs[i].rx, 1'b1, vecs[i].lat, vecs[i].sat);
      drain();
    end
    check("tbl_count", {32'd0, stat_count}, 64'd8);
    check("tbl_min",   {32'd0, stat_min}, 64'h00000001);
    check("tbl_max",   {32'd0, stat_max}, 64'hFFFFFFFF);

    // Min/max over 100, 300, 200 ns.
    clear_stats();
    push_tx(mk(1, 0, 0)); send_rx(mk(1, 100, 0), 1'b1, 32'h00640000, 1'b0);
    push_tx(mk(1, 0, 0)); send_rx(mk(1, 300, 0), 1'b1, 32'h012C0000, 1'b0);
    push_tx(mk(1, 0, 0)); send_rx(mk(1, 200, 0), 1'b1, 32'h00C80000, 1'b0);
    drain();
    check("mm_count", {32'd0, stat_count}, 64'd3);
    check("mm_min",   {32'd0, stat_min}, 64'h00640000);
    check("mm_max",   {32'd0, stat_max}, 64'h012C0000);
    clear_stats();
    check("mm_clr_count", {32'd0, stat_count}, 64'd0);
    check("mm_clr_min",   {32'd0, stat_min}, 64'hFFFFFFFF);
    check("mm_clr_max",   {32'd0, stat_max}, 64'd0);

    // FIFO full, fifth push held off, FIFO-order pairing.
    for (int i = 0; i < 4; i++) push_tx(mk(1, 1000 * i, 0));
    check("full_level", {61'd0, fifo_level}, 64'd4);
    check("full_ready", {63'd0, tx_ready}, 64'd0);
    tx_valid = 1'b1; tx_ts = mk(1, 4000, 0);
    tick(); tick();
    check("full_hold_level", {61'd0, fifo_level}, 64'd4);
    sbq.push_back('{lat: 32'h000A0000, sat: 1'b0});
    rx_valid = 1'b1; rx_ts = mk(1, 10, 0);
    tick();
    rx_valid = 1'b0;
    check("pop_ready", {63'd0, tx_ready}, 64'd1);
    check("pop_level", {61'd0, fifo_level}, 64'd3);
    tick();
    tx_valid = 1'b0;
    check("refill_level", {61'd0, fifo_level}, 64'd4);
    for (int i = 1; i < 5; i++)
      send_rx(mk(1, 1000 * i + 10 * (i + 1), 0), 1'b1, 32'(10 * (i + 1)) << 16, 1'b0);
    drain();
    check("fifo_drained", {61'd0, fifo_level}, 64'd0);

    // Timeout loss.
    clear_stats();
    push_tx(mk(1, 0, 0));
    begin
      int k = 0;
      while (fifo_level != 0 && k < 300) begin tick(); k++; end
      check("tmo_delay_in_range", {63'd0, (k >= 100 && k <= 102)}, 64'd1);
    end
    check("tmo_lost",  {32'd0, stat_lost}, 64'd1);
    check("tmo_level", {61'd0, fifo_level}, 64'd0);
    check("tmo_count", {32'd0, stat_count}, 64'd0);

    // Match arriving in the timeout cycle wins.
    clear_stats();
    push_tx(mk(1, 0, 0));
    repeat (100) tick();
    sbq.push_back('{lat: 32'h00320000, sat: 1'b0});
    rx_valid = 1'b1; rx_ts = mk(1, 50, 0);
    tick();
    rx_valid = 1'b0;
    drain();
    check("race_lost",  {32'd0, stat_lost}, 64'd0);
    check("race_count", {32'd0, stat_count}, 64'd1);
    check("race_level", {61'd0, fifo_level}, 64'd0);

    // Backpressure with both stages full.
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_tx(mk(1, 0, 0));
    send_rx(mk(1, 111, 0), 1'b1, 32'h006F0000, 1'b0);
    send_rx(mk(1, 222, 0), 1'b1, 32'h00DE0000, 1'b0);
    check("bp_rx_ready", {63'd0, rx_ready}, 64'd0);
    check("bp_valid",    {63'd0, m_valid}, 64'd1);
    held = m_lat;
    check("bp_first", {32'd0, held}, 64'h006F0000);
    sbq.push_back('{lat: 32'h014D0000, sat: 1'b0});
    rx_valid = 1'b1; rx_ts = mk(1, 333, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_lat",   {32'd0, m_lat}, 64'h006F0000);
      check("bp_hold_ready", {63'd0, rx_ready}, 64'd0);
    end
    check("bp_level", {61'd0, fifo_level}, 64'd1);
    m_ready = 1'b1;
    tick();
    rx_valid = 1'b0;
    drain();
    check("bp_count", {32'd0, stat_count}, 64'd3);
    check("bp_lost",  {32'd0, stat_lost}, 64'd0);

    // Reset in the middle of traffic.
    push_tx(mk(1, 0, 0));
    push_tx(mk(1, 0, 0));
    send_rx(mk(1, 77, 0), 1'b1, 32'h004D0000, 1'b0);
    check("pre_rst_count", {32'd0, stat_count}, 64'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, m_valid}, 64'd0);
    check("mid_rst_lat",   {32'd0, m_lat}, 64'd0);
    check("mid_rst_level", {61'd0, fifo_level}, 64'd0);
    check("mid_rst_count", {32'd0, stat_count}, 64'd0);
    check("mid_rst_min",   {32'd0, stat_min}, 64'hFFFFFFFF);
    sbq.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    push_tx(mk(2, 0, 0));
    send_rx(mk(2, 5, 0), 1'b1, 32'h00050000, 1'b0);
    drain();
    check("post_rst_count", {32'd0, stat_count}, 64'd1);
    check("post_rst_level", {61'd0, fifo_level}, 64'd0);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ptp_ts_loopback_latency.md
Name: ptp_ts_loopback_latency

Overview:
- Pairs PTP egress timestamps from the 10G MAC with the matching ingress timestamps from the same frames returning on a loopback path, in FIFO order.
- Computes per-frame loopback latency in fractional nanoseconds and keeps running min/max/count statistics.
- Sits in the logic clock domain, next to eth_mac_10g_fifo.
- Successor of the single-channel TS-check bench logic: supports 64-bit and 96-bit TS formats, configurable depth, timeout-based loss detection, and saturation flagging.

Parameters:
- PTP_TS_WIDTH, 96, timestamp format. Must be 96 or 64.
  - 96: {sec[95:48], ns[47:16], fns[15:0]}, ns wraps at 1e9.
  - 64: {ns[63:16], fns[15:0]}, free-running.
- FIFO_DEPTH, 16, pending egress timestamp entries. Power of two, 2..256.
- LAT_WIDTH, 32, latency output width in units of 2^-16 ns.
- TIMEOUT, 65535, cycles a head entry may wait for its ingress timestamp. 0 disables the timeout.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  logic clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tx_ts  in  PTP_TS_WIDTH  egress timestamp
- s_axis_tx_ts_valid  in  1
- s_axis_tx_ts_ready  out  1
- s_axis_rx_ts  in  PTP_TS_WIDTH  ingress timestamp
- s_axis_rx_ts_valid  in  1
- s_axis_rx_ts_ready  out  1
- m_axis_lat  out  LAT_WIDTH  latency (rx-tx) in fns units
- m_axis_lat_sat  out  1  latency clamped
- m_axis_lat_valid  out  1
- m_axis_lat_ready  in  1
- stat_clear  in  1  synchronous clear of statistics
- stat_count  out  CNT_WIDTH  matched pairs
- stat_lost  out  CNT_WIDTH  egress entries dropped by timeout
- stat_orphan  out  CNT_WIDTH  ingress timestamps with empty FIFO
- stat_min  out  LAT_WIDTH
- stat_max  out  LAT_WIDTH
- fifo_level  out  $clog2(FIFO_DEPTH)+1

Behaviour:

Reset (rst_n low, async):
- FIFO empty, pipeline empty, timeout counter 0.
- All outputs 0 except stat_min = all ones.
- Reset mid-operation discards pending entries and any in-flight result.

Egress FIFO:
- s_axis_tx_ts_ready = (fifo_level < FIFO_DEPTH).
- Push on valid&ready. No push when full, so no overflow is possible.
- Push and pop in the same cycle are allowed; the level is unchanged.
- fifo_level is registered and reflects the state after the cycle's push/pop.

Matching:
- s_axis_rx_ts_ready = stage-1 register free or advancing (i.e. !s1_valid || !s2_valid || m_axis_lat_ready).
- RX accept with FIFO non-empty: pop head, load stage 1 with {rx, tx}.
- RX accept with FIFO empty: no output; stat_orphan++.

Timeout:
- The counter increments each cycle the FIFO is non-empty and no pop occurs; it resets to 0 on any pop or when the FIFO is empty.
- When the counter reaches TIMEOUT: pop head, stat_lost++, counter reset.
- RX match and timeout in the same cycle: the match wins and the loss is not counted.

Arithmetic, stage 1:
- 96-bit format:
  - d_sec = rx.sec - tx.sec.
  - d_sec == 0: dns = rx.ns - tx.ns.
  - d_sec == 1: dns = rx.ns + 1_000_000_000 - tx.ns.
  - Otherwise: sat_hi if d_sec > 1, sat_lo if rx.sec < tx.sec.
- 64-bit format: dns = rx.ns - tx.ns (signed 49-bit).
- dfns = rx.fns - tx.fns (signed).

Arithmetic, stage 2:
- lat = (dns << 16) + dfns, signed.
- If lat < 0 or sat_lo: output 0 with sat = 1.
- If lat >= 2^LAT_WIDTH or sat_hi: output all ones with sat = 1.
- Otherwise output lat with sat = 0.

Latency and output handshake:
- Output valid 2 cycles after RX accept when unstalled.
- AXI-stream semantics on the output: data is held stable while valid && !ready.
- Full throughput: one pair per cycle.

Statistics:
- Updated when a result enters stage 2.
- stat_count++. If sat = 0, update min/max; saturated results are not included in min/max.
- All counters saturate at all ones.
- stat_clear: count/lost/orphan = 0, max = 0, min = all ones.
- Any statistic event in the same cycle as stat_clear is discarded (clear wins).

Test Plan:
- 96b, tx {sec=5, ns=1000, fns=0}, rx {sec=5, ns=1650, fns=0x8000} -> m_axis_lat = 0x028A8000, sat = 0, valid 2 cycles after rx accept; stat_count = 1, min = max = 0x028A8000.
- Second rollover: tx {7, 999_999_900, 0}, rx {8, 100, 0} -> lat = 0x00C80000, sat = 0. Also rx.sec - tx.sec = 2 -> 0xFFFFFFFF, sat = 1. Also rx earlier than tx -> 0, sat = 1; min/max unchanged.
- FIFO_DEPTH = 4: push 5 egress timestamps with no RX -> tx_ready low after the 4th, fifo_level = 4. Then one RX -> pairs with the first pushed entry; tx_ready high the next cycle.
- TIMEOUT = 100: one egress timestamp, no RX -> entry popped after 100 cycles, stat_lost = 1, fifo_level = 0. RX arriving on the timeout cycle -> matched, stat_lost stays 0.
- RX with empty FIFO -> no output valid, stat_orphan = 1. Then latencies 100/300/200 ns -> stat_min = 0x00640000, stat_max = 0x012C0000, stat_count = 3. stat_clear -> count 0, min = 0xFFFFFFFF, max = 0.
- Backpressure: hold m_axis_lat_ready low while 3 pairs arrive -> rx_ready drops once both stages are full, output data stays stable, no loss. Release -> 3 results emitted in order.
- Also assert rst_n mid-stream -> all outputs return to reset values immediately.
